async_receiver_scard: RTL and testbench
=======================================

Name: async_receiver_scard

Overview:
ISO 7816-3 character receiver for the smartcard I/O line. It is the receive-side counterpart to the smartcard transmitter on the same half-duplex line. Each character is a start bit, 8 data bits sent LSB first (direct convention), an even parity bit, then guard/stop time. The block oversamples the line at 16x baud, reassembles each character, checks parity and framing, and presents the byte to the smartcard register interface with a one-cycle strobe.

Parameters:
ClkFrequency, `UART_CLK (40 MHz), system clock frequency in Hz.
Baud, 9600, line rate in bit/s (1 etu = 1/Baud).
BaudGeneratorAccWidth, 16, width of the oversample phase accumulator; the carry bit is an extra bit above it.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
RxD  input  1  smartcard I/O line, idle high, asynchronous to clk
RxD_data  output  8  last received byte; held until the next character completes
RxD_data_ready  output  1  one-cycle strobe when a character completes
RxD_parity_error  output  1  valid with RxD_data_ready; 1 = received parity != XOR of data
RxD_frame_error  output  1  valid with RxD_data_ready; 1 = guard sample low
RxD_idle  output  1  high while the FSM is in IDLE
RxD_errsig  output  1  request to pull the I/O line low (ISO error signal); tied 0 unless the macro is defined

Behaviour:
- Reset (rst=0, asynchronous): sync flops=1, FSM=IDLE, accumulator=0, RxD_data=0, RxD_data_ready=0, both errors=0, RxD_errsig=0, RxD_idle=1. Reset mid-character discards the partial byte and produces no strobe.
- Synchroniser: RxD passes through 2 flops before any use.
- Oversample tick: one-cycle pulse from the accumulator carry. Increment = round(Baud*16*2^W / ClkFrequency), W = BaudGeneratorAccWidth (252 at 40 MHz/9600). The accumulator runs only outside IDLE. It clears to 0 on the start edge so bit timing aligns to that edge.
- Tick counter: 4 bits, wraps 15->0. Each bit is decided on the tick-8 sample by majority of the tick-7, tick-8 and tick-9 samples.
- FSM states:
  - IDLE: a falling edge on the synced line moves to START.
  - START: if the majority sample is high, treat it as a glitch and return to IDLE with no strobe and no error; otherwise move to D0.
  - D0..D7: shift each bit in LSB-first.
  - PAR: sample the parity bit; parity_err = sample ^ (XOR of data).
  - GUARD: sample at 10.5 etu; frame_err = ~sample. On the cycle after this sample, strobe RxD_data_ready, update RxD_data and both error flags, then go to WAITHI (or ERRSIG when the macro is enabled and parity failed).
  - WAITHI: stay until the synced line is high, then go to IDLE. A line held low (break) therefore yields exactly one character with frame_err=1 and no retrigger.
- Latency: the strobe comes 1 clk after the guard-sample tick, about 10.5 etu + 3 clk after the start edge.
- Back-to-back characters separated by a minimum 2 etu guard time are received without loss.

Optional Feature:
Macro SCARD_RX_ERRSIG_EN.
- Defined: on a parity error, state ERRSIG asserts RxD_errsig from the cycle after the strobe for exactly 16 ticks (1 etu), then deasserts and goes to WAITHI. Board logic ANDs RxD_errsig into the open-drain line driver so the card retransmits.
- Undefined: ERRSIG is not built and RxD_errsig is constant 0. A parity error only sets the flag.

Decomposition:
- Shared include (includes.v): `UART_CLK, the FSM state encodings (4-bit) and the majority-sample tick indices (7/8/9).
- One sub-module, scard_oversample_tick. Inputs: clk, rst, enable, clear. Output: tick. Shared with any future 16x smartcard logic.

Test Plan:
1. Send 0xA5 (four 1s, parity bit 0) at 9600 baud -> one strobe, RxD_data=0xA5, parity_error=0, frame_error=0, strobe about 10.5 etu after the start edge.
2. Send TS byte 0x3B (five 1s, parity bit 1), then 0x00 (parity 0) after a 2 etu guard -> two strobes in order, both error-free.
3. Send 0x3B with parity bit 0 -> RxD_data=0x3B, parity_error=1. With SCARD_RX_ERRSIG_EN, RxD_errsig is high for exactly 16 ticks; without it, RxD_errsig stays 0.
4. Drive a low glitch of 4 oversample ticks, then idle -> no strobe, RxD_idle returns to 1.
5. Hold RxD low for 20 etu, then release -> exactly one strobe with frame_error=1, RxD_data=0x00, parity_error=0; the next valid 0x55 is received cleanly.
6. Assert rst during bit D4 of 0xFF, release, then send 0x12 -> no strobe for the aborted byte; 0x12 is received correctly and all outputs were 0 during reset.

Source files
------------

// File: rtl/async_receiver_scard_pkg.sv
// Shared definitions for the smartcard receive path: default clock, FSM encoding,
// majority-sample tick indices and small helpers.
package async_receiver_scard_pkg;

    localparam int UART_CLK = 40_000_000;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_D0     = 4'd2,
        ST_D1     = 4'd3,
        ST_D2     = 4'd4,
        ST_D3     = 4'd5,
        ST_D4     = 4'd6,
        ST_D5     = 4'd7,
        ST_D6     = 4'd8,
        ST_D7     = 4'd9,
        ST_PAR    = 4'd10,
        ST_GUARD  = 4'd11,
        ST_WAITHI = 4'd12,
        ST_ERRSIG = 4'd13
    } rx_state_e;

    localparam logic [3:0] TICK_S0 = 4'd7;
    localparam logic [3:0] TICK_S1 = 4'd8;
    localparam logic [3:0] TICK_S2 = 4'd9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // round(baud * 16 * 2^w / clk_hz), computed in 64 bits
    function automatic int baud_inc(input longint clk_hz, input longint baud, input int w);
        return int'(((baud << (w + 4)) + clk_hz / 2) / clk_hz);
    endfunction

endpackage

// File: rtl/async_receiver_scard_tick.sv
// 16x-baud oversample tick from a phase accumulator carry; held at zero while disabled.
module scard_oversample_tick #(
    parameter int W   = 16,
    parameter int Inc = 252
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [W:0] INC_V = (W + 1)'(Inc);

    logic [W:0] acc_q, acc_d;

    always_comb begin
        acc_d = '0;
        if (!clear && enable)
            acc_d = {1'b0, acc_q[W-1:0]} + INC_V;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
    end

    assign tick = acc_q[W] & enable;

endmodule

// File: rtl/async_receiver_scard.sv
// ISO 7816-3 character receiver: 16x oversampling, 2-of-3 majority per bit, even parity
// and guard checks. Optional ISO error signalling is built when SCARD_RX_ERRSIG_EN is defined.
module async_receiver_scard
    import async_receiver_scard_pkg::*;
#(
    parameter int ClkFrequency          = UART_CLK,
    parameter int Baud                  = 9600,
    parameter int BaudGeneratorAccWidth = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_parity_error,
    output logic       RxD_frame_error,
    output logic       RxD_idle,
    output logic       RxD_errsig
);

    localparam int INC = baud_inc(longint'(ClkFrequency), longint'(Baud), BaudGeneratorAccWidth);

    logic       rx_meta_q, rx_sync_q, rx_last_q;
    rx_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       s7_q, s7_d, s8_q, s8_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_err_q, parity_err_d;
    logic [7:0] data_q, data_d;
    logic       ready_q, ready_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       idle_q, idle_d;
    logic       tick, clear, enable;
    logic [3:0] idx;
    logic       bit_dec, sample;
`ifdef SCARD_RX_ERRSIG_EN
    logic       errsig_q, errsig_d;
    logic [3:0] errcnt_q, errcnt_d;
`endif

    assign enable = (state_q != ST_IDLE);

    scard_oversample_tick #(
        .W   (BaudGeneratorAccWidth),
        .Inc (INC)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .clear  (clear),
        .tick   (tick)
    );

    // The bit value is committed on the last of the three samples (tick 9), centred on tick 8.
    assign idx     = cnt_q + 4'd1;
    assign bit_dec = tick && (idx == TICK_S2);
    assign sample  = maj3(s7_q, s8_q, rx_sync_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        s7_d         = s7_q;
        s8_d         = s8_q;
        shift_d      = shift_q;
        parity_err_d = parity_err_q;
        data_d       = data_q;
        ready_d      = 1'b0;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        clear        = 1'b0;
`ifdef SCARD_RX_ERRSIG_EN
        errsig_d     = 1'b0;
        errcnt_d     = errcnt_q;
`endif
        if (tick) begin
            cnt_d = idx;
            if (idx == TICK_S0) s7_d = rx_sync_q;
            if (idx == TICK_S1) s8_d = rx_sync_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (rx_last_q && !rx_sync_q) begin
                    state_d = ST_START;
                    clear   = 1'b1;
                    cnt_d   = 4'd0;
                end
            end
            ST_START: begin
                if (bit_dec) state_d = sample ? ST_IDLE : ST_D0;
            end
            ST_D0, ST_D1, ST_D2, ST_D3, ST_D4, ST_D5, ST_D6, ST_D7: begin
                if (bit_dec) begin
                    shift_d = {sample, shift_q[7:1]};
                    state_d = rx_state_e'(state_q + 4'd1);
                end
            end
            ST_PAR: begin
                if (bit_dec) begin
                    parity_err_d = sample ^ (^shift_q);
                    state_d      = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (bit_dec) begin
                    data_d  = shift_q;
                    perr_d  = parity_err_q;
                    ferr_d  = ~sample;
                    ready_d = 1'b1;
                    state_d = ST_WAITHI;
`ifdef SCARD_RX_ERRSIG_EN
                    if (parity_err_q) begin
                        state_d  = ST_ERRSIG;
                        errcnt_d = 4'd0;
                    end
`endif
                end
            end
            ST_WAITHI: begin
                if (rx_sync_q) state_d = ST_IDLE;
            end
`ifdef SCARD_RX_ERRSIG_EN
            ST_ERRSIG: begin
                errsig_d = 1'b1;
                if (tick) begin
                    errcnt_d = errcnt_q + 4'd1;
                    if (errcnt_q == 4'd15) begin
                        errsig_d = 1'b0;
                        state_d  = ST_WAITHI;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_last_q    <= 1'b1;
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            s7_q         <= 1'b1;
            s8_q         <= 1'b1;
            shift_q      <= 8'h00;
            parity_err_q <= 1'b0;
            data_q       <= 8'h00;
            ready_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            rx_meta_q    <= RxD;
            rx_sync_q    <= rx_meta_q;
            rx_last_q    <= rx_sync_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s7_q         <= s7_d;
            s8_q         <= s8_d;
            shift_q      <= shift_d;
            parity_err_q <= parity_err_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            idle_q       <= idle_d;
        end
    end

`ifdef SCARD_RX_ERRSIG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errsig_q <= 1'b0;
            errcnt_q <= 4'd0;
        end else begin
            errsig_q <= errsig_d;
            errcnt_q <= errcnt_d;
        end
    end
    assign RxD_errsig = errsig_q;
`else
    assign RxD_errsig = 1'b0;
`endif

    assign RxD_data         = data_q;
    assign RxD_data_ready   = ready_q;
    assign RxD_parity_error = perr_q;
    assign RxD_frame_error  = ferr_q;
    assign RxD_idle         = idle_q;

endmodule

// File: tb/tb_async_receiver_scard.sv
// Directed bench for async_receiver_scard; baud chosen so 1 etu = 64 clocks (tick every 4).
module tb_async_receiver_scard;

    localparam int ETU = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] RxD_data;
    logic       RxD_data_ready, RxD_parity_error, RxD_frame_error, RxD_idle, RxD_errsig;

    int vectors = 0, miscompares = 0;
    int cyc = 0, strobes = 0, strobe_cyc = 0, edge_cyc = 0, errsig_cycles = 0;
    int base, lat;
    logic [7:0] cap_data = 8'h00;
    logic       cap_pe = 1'b0, cap_fe = 1'b0;

    async_receiver_scard #(
        .ClkFrequency          (40_000_000),
        .Baud                  (625_000),
        .BaudGeneratorAccWidth (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .RxD              (RxD),
        .RxD_data         (RxD_data),
        .RxD_data_ready   (RxD_data_ready),
        .RxD_parity_error (RxD_parity_error),
        .RxD_frame_error  (RxD_frame_error),
        .RxD_idle         (RxD_idle),
        .RxD_errsig       (RxD_errsig)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (RxD_data_ready) begin
            strobes    <= strobes + 1;
            strobe_cyc <= cyc;
            cap_data   <= RxD_data;
            cap_pe     <= RxD_parity_error;
            cap_fe     <= RxD_frame_error;
        end
        if (RxD_errsig) errsig_cycles <= errsig_cycles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        repeat (ETU) @(negedge clk);
    endtask

    // start, 8 data LSB first, even parity (optionally inverted), 2 etu high guard
    task automatic send_char(input logic [7:0] d, input logic flip);
        @(negedge clk);
        edge_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((^d) ^ flip);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic chk_char(input string tag, input int exp_cnt, input logic [7:0] d,
                            input logic pe, input logic fe);
        chk({tag, "_count"}, strobes, exp_cnt);
        chk({tag, "_data"}, {24'd0, cap_data}, {24'd0, d});
        chk({tag, "_perr"}, {31'd0, cap_pe}, {31'd0, pe});
        chk({tag, "_ferr"}, {31'd0, cap_fe}, {31'd0, fe});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"},   {24'd0, RxD_data}, 32'h0);
        chk({tag, "_ready"},  {31'd0, RxD_data_ready}, 32'h0);
        chk({tag, "_perr"},   {31'd0, RxD_parity_error}, 32'h0);
        chk({tag, "_ferr"},   {31'd0, RxD_frame_error}, 32'h0);
        chk({tag, "_idle"},   {31'd0, RxD_idle}, 32'h1);
        chk({tag, "_errsig"}, {31'd0, RxD_errsig}, 32'h0);
    endtask

    initial begin
        // reset state
        repeat (5) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // 1: 0xA5, latency ~10.5 etu + sync/strobe delay (680 clocks expected)
        send_char(8'hA5, 1'b0);
        chk_char("a5", 1, 8'hA5, 1'b0, 1'b0);
        lat = strobe_cyc - edge_cyc;
        chk("a5_latency_window", {31'd0, (lat >= 672 && lat <= 690)}, 32'h1);
        chk("a5_idle_after", {31'd0, RxD_idle}, 32'h1);

        // 2: TS 0x3B then 0x00 with 2 etu guard
        send_char(8'h3B, 1'b0);
        chk_char("ts3b", 2, 8'h3B, 1'b0, 1'b0);
        send_char(8'h00, 1'b0);
        chk_char("b2b00", 3, 8'h00, 1'b0, 1'b0);

        // 3: 0x3B with wrong parity
        errsig_cycles = 0;
        send_char(8'h3B, 1'b1);
        repeat (ETU) @(negedge clk);
        chk_char("perr3b", 4, 8'h3B, 1'b1, 1'b0);
`ifdef SCARD_RX_ERRSIG_EN
        chk("errsig_16ticks", {31'd0, (errsig_cycles >= 60 && errsig_cycles <= 68)}, 32'h1);
`else
        chk("errsig_off", errsig_cycles, 32'd0);
`endif

        // 4: 4-tick low glitch
        base = strobes;
        RxD = 1'b0;
        repeat (16) @(negedge clk);
        RxD = 1'b1;
        repeat (3 * ETU) @(negedge clk);
        chk("glitch_no_strobe", strobes, base);
        chk("glitch_idle", {31'd0, RxD_idle}, 32'h1);

        // 5: 20 etu break, then a clean 0x55
        RxD = 1'b0;
        repeat (20 * ETU) @(negedge clk);
        RxD = 1'b1;
        repeat (2 * ETU) @(negedge clk);
        chk_char("break", base + 1, 8'h00, 1'b0, 1'b1);
        send_char(8'h55, 1'b0);
        chk_char("after_break55", base + 2, 8'h55, 1'b0, 1'b0);

        // 6: reset during D4 of 0xFF
        base = strobes;
        @(negedge clk);
        RxD = 1'b0;
        repeat (ETU) @(negedge clk);
        RxD = 1'b1;
        repeat (4 * ETU + ETU / 2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("midreset");
        repeat (7) @(negedge clk);
        rst = 1'b1;
        repeat (12 * ETU) @(negedge clk);
        chk("aborted_no_strobe", strobes, base);
        send_char(8'h12, 1'b0);
        chk_char("post_reset12", base + 1, 8'h12, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
